// File: rtl/trig_pkg.sv
// Shared types and constants for the tank sin/cos lookup arbiter.
// Holds width defaults, FSM states, the signed trig type and the quarter table.
package trig_pkg;

    localparam int ANGLE_W_DEF = 6;
    localparam int TRIG_W_DEF  = 8;
    localparam int TRIG_ONE    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STORE = 2'd2
    } state_t;

    typedef logic signed [TRIG_W_DEF-1:0] trig_t;

    // round(64*sin(k*pi/32)) for k = 0..16
    function automatic int quarter_tab(input int k);
        int v;
        unique case (k)
            0:  v = 0;
            1:  v = 6;
            2:  v = 12;
            3:  v = 19;
            4:  v = 24;
            5:  v = 30;
            6:  v = 36;
            7:  v = 41;
            8:  v = 45;
            9:  v = 49;
            10: v = 53;
            11: v = 56;
            12: v = 59;
            13: v = 61;
            14: v = 63;
            15: v = 64;
            16: v = 64;
            default: v = 0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/trig_quarter_rom.sv
// Quarter-wave sine table, 17 entries, two synchronous read ports.
// Data appears one clock after the address is presented with en high.
module trig_quarter_rom
    import trig_pkg::*;
#(
    parameter int TRIG_W = TRIG_W_DEF,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] sin_addr,
    input  logic [ADDR_W-1:0] cos_addr,
    output logic [TRIG_W-1:0] sin_q,
    output logic [TRIG_W-1:0] cos_q
);

    always_ff @(posedge clk) begin
        if (en) begin
            sin_q <= TRIG_W'(quarter_tab(int'(sin_addr)));
            cos_q <= TRIG_W'(quarter_tab(int'(cos_addr)));
        end
    end

endmodule

// File: rtl/trig_arbiter.sv
// Two-tank round-robin arbiter around a shared quarter-wave sin/cos lookup.
// Optional TRIG_ANGLE_CACHE_EN: repeat of a tank's last angle skips the ROM.
module trig_arbiter
    import trig_pkg::*;
#(
    parameter int ANGLE_W = ANGLE_W_DEF,
    parameter int TRIG_W  = TRIG_W_DEF
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [1:0]               req,
    input  logic [ANGLE_W-1:0]       angle1,
    input  logic [ANGLE_W-1:0]       angle2,
    output logic [1:0]               gnt,
    output logic                     rsp_valid,
    output logic                     rsp_id,
    output logic signed [TRIG_W-1:0] sin1,
    output logic signed [TRIG_W-1:0] cos1,
    output logic signed [TRIG_W-1:0] sin2,
    output logic signed [TRIG_W-1:0] cos2
);

    localparam int AW = ANGLE_W - 1;

    state_t             state;
    logic               ptr;
    logic               id;
    logic [ANGLE_W-1:0] ang;
    logic               pick;
    logic [AW-1:0]      idx;
    logic [AW-1:0]      mir;
    logic [1:0]         quad;
    logic [TRIG_W-1:0]  sin_mag;
    logic [TRIG_W-1:0]  cos_mag;
    logic [TRIG_W-1:0]  sin_val;
    logic [TRIG_W-1:0]  cos_val;

`ifdef TRIG_ANGLE_CACHE_EN
    logic [ANGLE_W-1:0] last1;
    logic [ANGLE_W-1:0] last2;
    logic               hit;
`endif

    // Both pending: pointer decides; otherwise the lone requester wins.
    assign pick = (req == 2'b11) ? ptr : req[1];

    assign quad = ang[ANGLE_W-1 -: 2];
    assign idx  = {1'b0, ang[ANGLE_W-3:0]};
    assign mir  = AW'(1 << (ANGLE_W - 2)) - idx;

    trig_quarter_rom #(
        .TRIG_W (TRIG_W),
        .ADDR_W (AW)
    ) u_rom (
        .clk      (Clk),
        .en       (state == FETCH),
        .sin_addr (quad[0] ? mir : idx),
        .cos_addr (quad[0] ? idx : mir),
        .sin_q    (sin_mag),
        .cos_q    (cos_mag)
    );

    assign sin_val = quad[1] ? -sin_mag : sin_mag;
    assign cos_val = (quad[1] ^ quad[0]) ? -cos_mag : cos_mag;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            ptr       <= 1'b0;
            id        <= 1'b0;
            ang       <= '0;
            sin1      <= '0;
            sin2      <= '0;
            cos1      <= TRIG_W'(TRIG_ONE);
            cos2      <= TRIG_W'(TRIG_ONE);
`ifdef TRIG_ANGLE_CACHE_EN
            last1     <= '0;
            last2     <= '0;
            hit       <= 1'b0;
`endif
        end else begin
            gnt       <= 2'b00;
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state <= FETCH;
                        gnt   <= pick ? 2'b10 : 2'b01;
                        id    <= pick;
                        ang   <= pick ? angle2 : angle1;
                        ptr   <= ~pick;
`ifdef TRIG_ANGLE_CACHE_EN
                        hit   <= pick ? (angle2 == last2)
                                      : (angle1 == last1);
`endif
                    end
                end
                FETCH: begin
`ifdef TRIG_ANGLE_CACHE_EN
                    if (hit) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id;
                    end else begin
                        state <= STORE;
                    end
`else
                    state <= STORE;
`endif
                end
                STORE: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_id    <= id;
                    if (id) begin
                        sin2 <= sin_val;
                        cos2 <= cos_val;
                    end else begin
                        sin1 <= sin_val;
                        cos1 <= cos_val;
                    end
`ifdef TRIG_ANGLE_CACHE_EN
                    if (id) last2 <= ang;
                    else    last1 <= ang;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trig_arbiter.sv
// Scoreboard bench for trig_arbiter: directed lookups, round-robin, reset abort.
// Expected responses are queued at issue and checked by a rsp_valid monitor.
module tb_trig_arbiter;

`ifdef TRIG_ANGLE_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [1:0] req;
    logic [5:0] angle1;
    logic [5:0] angle2;
    logic [1:0] gnt;
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] sin1;
    logic [7:0] cos1;
    logic [7:0] sin2;
    logic [7:0] cos2;

    typedef struct {
        logic       id;
        logic [7:0] s;
        logic [7:0] c;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    trig_arbiter dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req       (req),
        .angle1    (angle1),
        .angle2    (angle2),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .sin1      (sin1),
        .cos1      (cos1),
        .sin2      (sin2),
        .cos2      (cos2)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic t, input logic [7:0] s,
                        input logic [7:0] c);
        exp_t e;
        e.id = t;
        e.s  = s;
        e.c  = c;
        sb.push_back(e);
    endtask

    // Monitor: every response must match the oldest queued expectation.
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Reset_n === 1'b1 && rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_id %0h, expected none",
                         rsp_id);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_sin", e.id ? sin2 : sin1, e.s);
                chk("rsp_cos", e.id ? cos2 : cos1, e.c);
            end
        end
    end

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        req     = 2'b00;
        angle1  = '0;
        angle2  = '0;
        repeat (2) @(negedge Clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_sin1", sin1, 8'h00);
        chk("rst_cos1", cos1, 8'h40);
        chk("rst_sin2", sin2, 8'h00);
        chk("rst_cos2", cos2, 8'h40);
        Reset_n = 1'b1;
    endtask

    // Requester: drops each bit as its gnt appears, then scrambles that angle.
    task automatic issue(input logic [1:0] r, input logic [5:0] a1,
                         input logic [5:0] a2);
        int n;
        int w;
        n = int'(r[0]) + int'(r[1]);
        @(negedge Clk);
        req    = r;
        angle1 = a1;
        angle2 = a2;
        for (int k = 0; k < n; k++) begin
            w = 0;
            do begin
                @(negedge Clk);
                w++;
            end while (gnt == 2'b00 && w < 20);
            chk("gnt_onehot", 32'($onehot(gnt)), 1);
            if (gnt[0]) angle1 = a1 ^ 6'h15;
            if (gnt[1]) angle2 = a2 ^ 6'h2A;
            req = req & ~gnt;
        end
        w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(negedge Clk);
            w++;
        end
        chk("drain", 32'(sb.size()), 0);
    endtask

    // Cycle-exact single lookup on tank 1.
    task automatic timed1(input logic [5:0] a, input logic [7:0] s,
                          input logic [7:0] c, input bit hit);
        push(1'b0, s, c);
        @(negedge Clk);
        req    = 2'b01;
        angle1 = a;
        @(negedge Clk);
        chk("lat_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        @(negedge Clk);
        chk("lat_rsp_t2", 32'(rsp_valid), 32'(hit));
        @(negedge Clk);
        chk("lat_rsp_t3", 32'(rsp_valid), 32'(!hit));
        chk("lat_sin1", sin1, s);
        @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        timed1(6'd0, 8'h00, 8'h40, CACHE);

        push(1'b1, 8'h40, 8'h00);
        issue(2'b10, 6'd0, 6'd16);
        push(1'b1, 8'hC0, 8'h00);
        issue(2'b10, 6'd0, 6'd48);

        push(1'b0, 8'hD3, 8'hD3);
        issue(2'b01, 6'd40, 6'd0);
        push(1'b0, 8'h2D, 8'h2D);
        issue(2'b01, 6'd8, 6'd0);
        push(1'b0, 8'h1E, 8'h38);
        issue(2'b01, 6'd5, 6'd0);
        push(1'b1, 8'h1E, 8'hC8);
        issue(2'b10, 6'd0, 6'd27);
        push(1'b0, 8'hFA, 8'h40);
        issue(2'b01, 6'd63, 6'd0);

        do_reset();
        push(1'b0, 8'h2D, 8'h2D);
        push(1'b1, 8'h40, 8'h00);
        issue(2'b11, 6'd8, 6'd16);
        push(1'b0, 8'hD3, 8'hD3);
        push(1'b1, 8'hC0, 8'h00);
        issue(2'b11, 6'd40, 6'd48);

        // Reset pulse while the angle-16 lookup sits in STORE.
        @(negedge Clk);
        req    = 2'b01;
        angle1 = 6'd16;
        @(negedge Clk);
        chk("abort_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        @(negedge Clk);
        Reset_n = 1'b0;
        #2;
        chk("abort_sin1", sin1, 8'h00);
        chk("abort_cos1", cos1, 8'h40);
        #1;
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
        chk("abort_hold_sin1", sin1, 8'h00);
        chk("abort_hold_cos1", cos1, 8'h40);

        timed1(6'd16, 8'h40, 8'h00, 1'b0);
        timed1(6'd16, 8'h40, 8'h00, CACHE);

        chk("tank2_sin_kept", sin2, 8'h00);
        chk("tank2_cos_kept", cos2, 8'h40);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
